// File: rtl/axis_pkt_gen.sv
// axis_pkt_gen: AXI-Stream ramp packet generator with a 2-entry registered skid buffer on the output.
// Optional define PKTGEN_TUSER_EN adds m_axis_tuser carrying the 0-based packet index.
module axis_pkt_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  input  logic [LEN_WIDTH-1:0]  pkt_count,
  input  logic [DATA_WIDTH-1:0] init_value,
  input  logic [DATA_WIDTH-1:0] step,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  done
`ifdef PKTGEN_TUSER_EN
  ,
  output logic [LEN_WIDTH-1:0]  m_axis_tuser
`endif
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  localparam logic [LEN_WIDTH-1:0] L0 = '0;
  localparam logic [LEN_WIDTH-1:0] L1 = LEN_WIDTH'(1);
`ifdef PKTGEN_TUSER_EN
  localparam int PW = DATA_WIDTH + 2 + LEN_WIDTH;
`else
  localparam int PW = DATA_WIDTH + 2;
`endif

  logic [0:0]            r_state;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_cnt;
  logic [LEN_WIDTH-1:0]  r_beat;
  logic [LEN_WIDTH-1:0]  r_pkt;
  logic [DATA_WIDTH-1:0] r_init;
  logic [DATA_WIDTH-1:0] r_step;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_gen_done;
  logic                  r_out_valid;
  logic [PW-1:0]         r_out;
  logic                  r_skid_valid;
  logic [PW-1:0]         r_skid;
  logic                  r_done;

  logic          w_start;
  logic          w_gen_fire;
  logic          w_last_beat;
  logic          w_last_pkt;
  logic          w_final;
  logic [PW-1:0] w_gen_pay;

  // Payload layout: {[user], final-beat-of-run, tlast, tdata}
  assign w_start     = (r_state == S_IDLE) && start && (pkt_len != L0) && (pkt_count != L0);
  assign w_gen_fire  = (r_state == S_RUN) && !r_gen_done && !r_skid_valid;
  assign w_last_beat = r_beat == r_len - L1;
  assign w_last_pkt  = r_pkt == r_cnt - L1;
  assign w_final     = r_out_valid && m_axis_tready && r_out[DATA_WIDTH+1];
`ifdef PKTGEN_TUSER_EN
  assign w_gen_pay    = {r_pkt, w_last_beat && w_last_pkt, w_last_beat, r_data};
  assign m_axis_tuser = r_out[PW-1 -: LEN_WIDTH];
`else
  assign w_gen_pay    = {w_last_beat && w_last_pkt, w_last_beat, r_data};
`endif

  assign m_axis_tdata  = r_out[DATA_WIDTH-1:0];
  assign m_axis_tlast  = r_out[DATA_WIDTH];
  assign m_axis_tvalid = r_out_valid;
  assign busy          = r_state == S_RUN;
  assign done          = r_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_len        <= L0;
      r_cnt        <= L0;
      r_beat       <= L0;
      r_pkt        <= L0;
      r_init       <= '0;
      r_step       <= '0;
      r_data       <= '0;
      r_gen_done   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out        <= '0;
      r_skid_valid <= 1'b0;
      r_skid       <= '0;
      r_done       <= 1'b0;
    end else begin
      r_done <= w_final;
      if (w_start) begin
        r_state    <= S_RUN;
        r_len      <= pkt_len;
        r_cnt      <= pkt_count;
        r_init     <= init_value;
        r_step     <= step;
        r_data     <= init_value;
        r_beat     <= L0;
        r_pkt      <= L0;
        r_gen_done <= 1'b0;
      end else if (w_final) begin
        r_state <= S_IDLE;
      end
      if (w_gen_fire) begin
        r_beat     <= w_last_beat ? L0 : r_beat + L1;
        r_data     <= w_last_beat ? r_init : r_data + r_step;
        r_pkt      <= w_last_beat ? r_pkt + L1 : r_pkt;
        r_gen_done <= w_last_beat && w_last_pkt;
      end
      // Generator only advances while the skid slot is free, so tready never reaches an output combinationally
      if (!r_out_valid || m_axis_tready) begin
        r_out_valid  <= r_skid_valid || w_gen_fire;
        r_out        <= r_skid_valid ? r_skid : w_gen_pay;
        r_skid_valid <= 1'b0;
      end else if (w_gen_fire) begin
        r_skid       <= w_gen_pay;
        r_skid_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_axis_pkt_gen.sv
// tb_axis_pkt_gen: randomized self-checking bench; a 32-bit and an 8-bit instance run in lockstep
// against a beat-index model (beat i -> packet i/len, data init+(i%len)*step).
module tb_axis_pkt_gen;
  logic        clk = 0;
  logic        reset, start, tready;
  logic [15:0] pkt_len, pkt_count;
  logic [31:0] init_value, step, tdata;
  logic [7:0]  tdata8;
  logic        tvalid, tlast, busy, done, tvalid8, tlast8, busy8, done8;
`ifdef PKTGEN_TUSER_EN
  logic [15:0] tuser, tuser8;
`endif

  always #5 clk = ~clk;

  axis_pkt_gen u_dut (
    .clk(clk), .reset(reset), .start(start), .pkt_len(pkt_len), .pkt_count(pkt_count),
    .init_value(init_value), .step(step), .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
    .m_axis_tready(tready), .m_axis_tlast(tlast), .busy(busy), .done(done)
`ifdef PKTGEN_TUSER_EN
    , .m_axis_tuser(tuser)
`endif
  );

  axis_pkt_gen #(.DATA_WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start), .pkt_len(pkt_len), .pkt_count(pkt_count),
    .init_value(init_value[7:0]), .step(step[7:0]), .m_axis_tdata(tdata8), .m_axis_tvalid(tvalid8),
    .m_axis_tready(tready), .m_axis_tlast(tlast8), .busy(busy8), .done(done8)
`ifdef PKTGEN_TUSER_EN
    , .m_axis_tuser(tuser8)
`endif
  );

  int checks = 0, failures = 0;
  logic [31:0] q_d32[$];
  logic [7:0]  q_d8[$];
  bit          q_last[$];
  logic [15:0] q_user[$];
  int first_n, final_n, done_n, extra, busy_err, proto_err;

  function automatic logic [31:0] exp_data(input logic [31:0] init, input logic [31:0] stp, input int len, input int i);
    return init + 32'(i % len) * stp;
  endfunction

  // Drives one run and records every handshaken beat plus timing/protocol observations.
  task automatic run_pkt(input int len, input int cnt, input logic [31:0] init, input logic [31:0] stp,
                         input int mode, input bit mid, input bit pre, input bit chain,
                         input int nlen, input logic [31:0] ninit, input logic [31:0] nstp);
    bit pv, pr, pl;
    logic [31:0] pd;
    logic [7:0] pd8;
    int limit;
    q_d32.delete(); q_d8.delete(); q_last.delete(); q_user.delete();
    first_n = 0; final_n = 0; done_n = 0; extra = 0; busy_err = 0; proto_err = 0;
    pv = 0; pr = 0; pl = 0; pd = 0; pd8 = 0;
    limit = len * cnt * 8 + 40;
    if (!pre) begin
      @(posedge clk); #1;
      start = 1; pkt_len = 16'(len); pkt_count = 16'(cnt); init_value = init; step = stp;
    end
    for (int n = 1; n <= limit; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        start = 0;
        pkt_len = 16'($urandom_range(1, 9)); pkt_count = 16'($urandom_range(1, 9));
        init_value = $urandom; step = $urandom;
      end
      if (mid && n == 3) start = 1;
      if (mid && n == 4) start = 0;
      if (tvalid8 !== tvalid || tlast8 !== tlast || busy8 !== busy || done8 !== done) proto_err++;
      if (pv && !pr && (!tvalid || tdata !== pd || tdata8 !== pd8 || tlast !== pl)) proto_err++;
      if (final_n == 0 && !busy) busy_err++;
      if (done) begin
        if (done_n == 0) begin
          done_n = n;
          if (busy) busy_err++;
        end else extra++;
      end
      if (tvalid && first_n == 0) first_n = n;
      tready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(n % 2) : ($urandom_range(0, 9) < 7);
      if (tvalid && tready) begin
        q_d32.push_back(tdata); q_d8.push_back(tdata8); q_last.push_back(tlast);
`ifdef PKTGEN_TUSER_EN
        q_user.push_back(tuser);
`else
        q_user.push_back('0);
`endif
        if (q_d32.size() == len * cnt) final_n = n;
      end
      pv = tvalid; pr = tready; pd = tdata; pd8 = tdata8; pl = tlast;
      if (done_n != 0) begin
        if (chain) begin
          start = 1; pkt_len = 16'(nlen); pkt_count = 16'(1); init_value = ninit; step = nstp;
        end
        break;
      end
    end
    if (done_n == 0) begin
      failures++;
      $display("FAIL run_timeout got=no_done exp=done_within_%0d_cycles", limit);
    end
    checks++;
    if (!chain) repeat (3) begin
      @(posedge clk); #1;
      if (tvalid || done || busy) extra++;
    end
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      checks++;
      if ({tvalid, tlast, busy, done, tvalid8, tlast8, busy8, done8} !== 8'h0) begin
        failures++;
        $display("FAIL reset_ctrl phase%0d got=%b exp=0", p, {tvalid, tlast, busy, done, tvalid8, tlast8, busy8, done8});
      end
      checks++;
      if (tdata !== 32'h0 || tdata8 !== 8'h0) begin
        failures++;
        $display("FAIL reset_data phase%0d got=%0h/%0h exp=0", p, tdata, tdata8);
      end
      reset = 0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_basic();
    logic [31:0] e;
    run_pkt(4, 2, 32'd10, 32'd3, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (q_d32.size() != 8) begin failures++; $display("FAIL basic_count got=%0d exp=8", q_d32.size()); end
    for (int i = 0; i < q_d32.size(); i++) begin
      e = exp_data(10, 3, 4, i);
      checks++;
      if (q_d32[i] !== e || q_d8[i] !== e[7:0] || q_last[i] !== (i % 4 == 3)) begin
        failures++;
        $display("FAIL basic_beat%0d got=%0d/%0d/%0b exp=%0d/%0b", i, q_d32[i], q_d8[i], q_last[i], e, i % 4 == 3);
      end
    end
    checks++;
    if (first_n != 2) begin failures++; $display("FAIL basic_latency got=%0d exp=2", first_n); end
    checks++;
    if (final_n - first_n != 7) begin failures++; $display("FAIL basic_consecutive got=%0d exp=7", final_n - first_n); end
    checks++;
    if (done_n != final_n + 1) begin failures++; $display("FAIL basic_done got=%0d exp=%0d", done_n, final_n + 1); end
    checks++;
    if (busy_err != 0 || proto_err != 0 || extra != 0) begin
      failures++;
      $display("FAIL basic_proto got=%0d/%0d/%0d exp=0/0/0", busy_err, proto_err, extra);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] e;
    run_pkt(4, 2, 32'd10, 32'd3, 1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (q_d32.size() != 8) begin failures++; $display("FAIL bp_count got=%0d exp=8", q_d32.size()); end
    for (int i = 0; i < q_d32.size(); i++) begin
      e = exp_data(10, 3, 4, i);
      checks++;
      if (q_d32[i] !== e || q_last[i] !== (i % 4 == 3)) begin
        failures++;
        $display("FAIL bp_beat%0d got=%0d/%0b exp=%0d/%0b", i, q_d32[i], q_last[i], e, i % 4 == 3);
      end
    end
    checks++;
    if (proto_err != 0 || busy_err != 0 || extra != 0 || done_n != final_n + 1) begin
      failures++;
      $display("FAIL bp_proto got=%0d/%0d/%0d/%0d exp=0/0/0/%0d", proto_err, busy_err, extra, done_n, final_n + 1);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] w8[4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    run_pkt(4, 1, 32'hFE, 32'd1, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (q_d8.size() != 4) begin failures++; $display("FAIL wrap_count got=%0d exp=4", q_d8.size()); end
    for (int i = 0; i < q_d8.size() && i < 4; i++) begin
      checks++;
      if (q_d8[i] !== w8[i]) begin failures++; $display("FAIL wrap_beat%0d got=%0h exp=%0h", i, q_d8[i], w8[i]); end
    end
    checks++;
    if (q_d32.size() > 2 && q_d32[2] !== 32'h100) begin failures++; $display("FAIL wrap_wide got=%0h exp=100", q_d32[2]); end
  endtask

  task automatic test_zero();
    int seen;
    for (int z = 0; z < 2; z++) begin
      @(posedge clk); #1;
      start = 1; pkt_len = z ? 16'd3 : 16'd0; pkt_count = z ? 16'd0 : 16'd2; tready = 1;
      @(posedge clk); #1;
      start = 0; seen = 0;
      repeat (20) begin
        if (tvalid || done || busy || tvalid8) seen++;
        @(posedge clk); #1;
      end
      checks++;
      if (seen != 0) begin failures++; $display("FAIL zero_start%0d got=%0d_active_cycles exp=0", z, seen); end
    end
  endtask

  task automatic test_start_in_run();
    logic [31:0] e;
    run_pkt(3, 2, 32'd100, 32'd7, 0, 1, 0, 0, 0, 0, 0);
    checks++;
    if (q_d32.size() != 6) begin failures++; $display("FAIL midstart_count got=%0d exp=6", q_d32.size()); end
    for (int i = 0; i < q_d32.size(); i++) begin
      e = exp_data(100, 7, 3, i);
      checks++;
      if (q_d32[i] !== e || q_last[i] !== (i % 3 == 2)) begin
        failures++;
        $display("FAIL midstart_beat%0d got=%0d/%0b exp=%0d/%0b", i, q_d32[i], q_last[i], e, i % 3 == 2);
      end
    end
    checks++;
    if (extra != 0 || busy_err != 0) begin failures++; $display("FAIL midstart_extra got=%0d/%0d exp=0/0", extra, busy_err); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    run_pkt(2, 1, 32'd5, 32'd5, 0, 0, 0, 1, 3, 32'd50, 32'd2);
    checks++;
    if (q_d32.size() != 2) begin failures++; $display("FAIL b2b_first_count got=%0d exp=2", q_d32.size()); end
    run_pkt(3, 1, 32'd50, 32'd2, 2, 0, 1, 0, 0, 0, 0);
    checks++;
    if (q_d32.size() != 3 || first_n != 2) begin
      failures++;
      $display("FAIL b2b_second got=%0d_beats_first@%0d exp=3_beats_first@2", q_d32.size(), first_n);
    end
    for (int i = 0; i < q_d32.size(); i++) begin
      e = exp_data(50, 2, 3, i);
      checks++;
      if (q_d32[i] !== e) begin failures++; $display("FAIL b2b_beat%0d got=%0d exp=%0d", i, q_d32[i], e); end
    end
  endtask

  task automatic test_reset_abort();
    int hs, seen;
    logic [31:0] ii, ss;
    ii = $urandom; ss = $urandom; hs = 0; seen = 0;
    @(posedge clk); #1;
    start = 1; pkt_len = 16'd5; pkt_count = 16'd1; init_value = ii; step = ss; tready = 1;
    for (int n = 0; n < 20 && hs < 3; n++) begin
      @(posedge clk); #1;
      start = 0;
      if (tvalid) hs++;
    end
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    checks++;
    if (tvalid || busy || done || tdata !== 32'h0) begin
      failures++;
      $display("FAIL abort_reset got=v%0b_b%0b_d%0b_data%0h exp=all_zero", tvalid, busy, done, tdata);
    end
    reset = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (tvalid || done || busy) seen++;
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL abort_quiet got=%0d_active_cycles exp=0", seen); end
    run_pkt(5, 1, ii, ss, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (q_d32.size() != 5 || q_d32[0] !== ii) begin
      failures++;
      $display("FAIL abort_rerun got=%0d_beats_first=%0h exp=5_beats_first=%0h", q_d32.size(), q_d32.size() ? q_d32[0] : 0, ii);
    end
  endtask

  task automatic test_random();
    int len, cnt, bad;
    logic [31:0] ii, ss, e;
    for (int r = 0; r < 12; r++) begin
      len = $urandom_range(1, 6); cnt = $urandom_range(1, 4); ii = $urandom; ss = $urandom; bad = 0;
      run_pkt(len, cnt, ii, ss, 2, r % 3 == 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < q_d32.size(); i++) begin
        e = exp_data(ii, ss, len, i);
        if (q_d32[i] !== e || q_d8[i] !== e[7:0] || q_last[i] !== (i % len == len - 1)) bad++;
      end
      checks++;
      if (bad != 0 || q_d32.size() != len * cnt || proto_err != 0 || busy_err != 0 || extra != 0 || done_n != final_n + 1) begin
        failures++;
        $display("FAIL random%0d got=bad%0d_n%0d_proto%0d_busy%0d_extra%0d_done%0d exp=bad0_n%0d_0_0_0_done%0d",
                 r, bad, q_d32.size(), proto_err, busy_err, extra, done_n, len * cnt, final_n + 1);
      end
    end
  endtask

`ifdef PKTGEN_TUSER_EN
  task automatic test_tuser();
    logic [15:0] e;
    run_pkt(2, 3, 32'd0, 32'd1, 2, 0, 0, 0, 0, 0, 0);
    checks++;
    if (q_user.size() != 6) begin failures++; $display("FAIL tuser_count got=%0d exp=6", q_user.size()); end
    for (int i = 0; i < q_user.size(); i++) begin
      e = 16'(i / 2);
      checks++;
      if (q_user[i] !== e) begin failures++; $display("FAIL tuser_beat%0d got=%0d exp=%0d", i, q_user[i], e); end
    end
  endtask
`endif

  initial begin
    reset = 1; start = 0; pkt_len = 0; pkt_count = 0; init_value = 0; step = 0; tready = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero();
    test_start_in_run();
    test_back_to_back();
    test_reset_abort();
    test_random();
`ifdef PKTGEN_TUSER_EN
    test_tuser();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axis_pkt_gen.md
AXIS_PKT_GEN -- requirements
Module: axis_pkt_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of m_axis_tdata, init_value and step.
REQ-002 SHALL have parameter LEN_WIDTH, default 16: width of pkt_len and pkt_count, and of the beat and packet counters.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request to begin a run; sampled only in IDLE.
REQ-006 SHALL have port pkt_len, input, LEN_WIDTH bits: beats per packet.
REQ-007 SHALL have port pkt_count, input, LEN_WIDTH bits: packets per run.
REQ-008 SHALL have port init_value, input, DATA_WIDTH bits: tdata of the first beat of each packet.
REQ-009 SHALL have port step, input, DATA_WIDTH bits: increment between consecutive beats.
REQ-010 SHALL have port m_axis_tdata, output, DATA_WIDTH bits: stream data.
REQ-011 SHALL have port m_axis_tvalid, output, 1 bit: stream valid.
REQ-012 SHALL have port m_axis_tready, input, 1 bit: stream ready.
REQ-013 SHALL have port m_axis_tlast, output, 1 bit: marks the last beat of a packet.
REQ-014 SHALL have port busy, output, 1 bit: run in progress.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse at the end of a run.

Function
REQ-016 SHALL implement a 2-state FSM:
- IDLE -> RUN when start=1, pkt_len!=0 and pkt_count!=0.
- RUN -> IDLE on the output handshake (tvalid & tready) of the last beat of the last packet.
REQ-017 SHALL latch pkt_len, pkt_count, init_value and step on the IDLE->RUN transition and ignore later changes to them until the next run.
REQ-018 SHALL ignore start when pkt_len=0 or pkt_count=0, remaining in IDLE with no beats and no done pulse.
REQ-019 SHALL ignore start while in RUN.
REQ-020 SHALL drive beat k (k = 0 .. pkt_len-1) of every packet with tdata = init_value + k*step, mod 2^DATA_WIDTH (wrap-around, no saturation).
REQ-021 SHALL assert m_axis_tlast on beat pkt_len-1 of every packet, and on every beat when pkt_len=1.
REQ-022 SHALL register the output through a 2-entry skid buffer:
- m_axis_tready SHALL have no combinational path to any output.
- Throughput SHALL be 1 beat per clock while m_axis_tready=1.
REQ-023 SHALL first assert m_axis_tvalid in the second cycle after the cycle in which start is sampled high (latency 2).
REQ-024 SHALL, once m_axis_tvalid is high, hold m_axis_tvalid, tdata and tlast stable until the handshake completes.
REQ-025 SHALL lose, duplicate or reorder no beat under any m_axis_tready pattern.
REQ-026 SHALL assert busy from the cycle after start is accepted through the cycle of the final handshake.
REQ-027 SHALL pulse done for exactly one cycle, the cycle after the final handshake, with busy=0 in that cycle.
REQ-028 SHALL accept a new start in the same cycle that done is high.

Reset
REQ-029 SHALL, while reset=1, set the FSM to IDLE, empty the skid buffer and clear all counters.
REQ-030 SHALL drive m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0, done=0 during reset and in the cycle after.
REQ-031 SHALL abort a run in progress on reset, with no done pulse and no further beats.

Configuration
REQ-032 SHALL recognise macro PKTGEN_TUSER_EN:
- Defined: add output m_axis_tuser, LEN_WIDTH bits, carrying the 0-based packet index. It SHALL follow the same stability rules as tdata and SHALL be 0 in reset.
- Undefined: port and logic absent; all other behaviour identical.

Verification
REQ-033 SHALL cover: tready=1, pkt_len=4, pkt_count=2, init=10, step=3 -> tdata 10,13,16,19,10,13,16,19; tlast on beats 3 and 7; 8 consecutive valid cycles; done 1 cycle after beat 7.
REQ-034 SHALL cover: same run with tready toggling 1,0,1,0 -> identical data sequence; tdata/tlast stable across stalled cycles.
REQ-035 SHALL cover: DATA_WIDTH=8, init=0xFE, step=1, pkt_len=4 -> tdata 0xFE,0xFF,0x00,0x01.
REQ-036 SHALL cover: start with pkt_len=0, and separately start pulsed during RUN -> no beats or done for the first; second start ignored, run unchanged.
REQ-037 SHALL cover: reset asserted after beat 2 of a 5-beat packet -> tvalid=0 next cycle, no done, busy=0; a new run afterwards starts at init_value.
REQ-038 SHALL cover: with PKTGEN_TUSER_EN, pkt_len=2, pkt_count=3 -> tuser 0,0,1,1,2,2.
